capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_capture_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// ============================================================================
// capture_ctrl -- pre/post-trigger sample capture into a circular buffer
//
// Fills an external single-port buffer (registered read, no output register)
// with ADC samples.
//   PRE   : fills PRETRIG samples of history.
//   ARMED : keeps writing and waits for a level crossing, a forced trigger or
//           an optional timeout.
//   POST  : writes the trigger sample, then 4095-PRETRIG more samples.
//   DONE  : the buffer holds one contiguous 2**ADDR_WIDTH-sample window. The
//           window is read out oldest-first with rd_start / rd_next.
//
// Ports
//   clka, rsta               clock, synchronous active-high reset
//   start                    begin a new capture; aborts capture or readout
//   adc_data, adc_valid      sample stream
//   trig_level, trig_edge    threshold (unsigned), 0 = rising, 1 = falling
//   force_trig               in ARMED, trigger on the next valid sample
//   rd_start, rd_next        readout control (DONE only)
//   rd_data, rd_valid,       readout stream; rd_last marks the final sample
//   rd_last
//   busy, done, trig_addr    status; trig_addr is the trigger sample's address
//   addra, dia, wea, doa     buffer port
//
// Build option
//   CAPTURE_TIMEOUT_EN : when defined, ARMED auto-triggers. After TIMEOUT
//                        clka cycles without a trigger, the next valid sample
//                        is treated as a forced trigger.
// ============================================================================
module capture_ctrl #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int PRETRIG    = 2048,
   parameter int TIMEOUT    = 1000000
) (
   input  logic                  clka,
   input  logic                  rsta,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_valid,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic                  trig_edge,
   input  logic                  force_trig,
   input  logic                  rd_start,
   input  logic                  rd_next,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic [ADDR_WIDTH-1:0] addra,
   output logic [DATA_WIDTH-1:0] dia,
   output logic                  wea,
   input  logic [DATA_WIDTH-1:0] doa
);

   localparam int DEPTH    = 1 << ADDR_WIDTH;
   localparam int CNT_W    = ADDR_WIDTH + 1;
   // Samples written after the trigger sample to complete the window.
   localparam int POST_LEN = DEPTH - 1 - PRETRIG;

   localparam logic [ADDR_WIDTH-1:0] PRE_LAST  = ADDR_WIDTH'(PRETRIG - 1);
   localparam logic [ADDR_WIDTH-1:0] POST_LAST = ADDR_WIDTH'((POST_LEN == 0) ? 0 : POST_LEN - 1);
   localparam logic [ADDR_WIDTH-1:0] PRE_OFFS  = ADDR_WIDTH'(PRETRIG);
   localparam logic [CNT_W-1:0]      RD_TOTAL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]      RD_FINAL  = CNT_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      ARMED,
      POST,
      DONE
   } state_t;

   state_t state_reg, state_next;

   // Write side
   logic [ADDR_WIDTH-1:0] wptr_reg;
   logic [ADDR_WIDTH-1:0] waddr_reg;
   logic [DATA_WIDTH-1:0] dia_reg;
   logic                  wea_reg;
   logic [ADDR_WIDTH-1:0] pre_cnt_reg;
   logic [ADDR_WIDTH-1:0] post_cnt_reg;

   // Trigger detection
   logic [DATA_WIDTH-1:0] prev_reg;
   logic                  prev_valid_reg;
   logic                  force_reg;
   logic [ADDR_WIDTH-1:0] trig_addr_reg;

   // Read side
   logic [ADDR_WIDTH-1:0] rptr_reg;
   logic [CNT_W-1:0]      rd_cnt_reg;      // reads issued since rd_start
   logic                  rd_active_reg;
   logic                  rd_s1_reg;       // address on the buffer this cycle
   logic                  rd_last_s1_reg;
   logic                  rd_valid_reg;
   logic                  rd_last_reg;

   // Combinational helpers
   logic in_capture;
   logic sample_en;
   logic rise_hit;
   logic fall_hit;
   logic edge_hit;
   logic timeout_hit;
   logic fire;
   logic rd_go_start;
   logic rd_go_next;

   // -------------------------------------------------------------------------
   // Optional ARMED timeout
   // -------------------------------------------------------------------------
`ifdef CAPTURE_TIMEOUT_EN
   logic [31:0] to_cnt_reg;

   // Holds at zero outside ARMED, so it is already clear on the first ARMED
   // cycle. It saturates at TIMEOUT until a sample consumes the trigger.
   always_ff @(posedge clka) begin
      if (rsta) begin
         to_cnt_reg <= '0;
      end else if (start || (state_reg != ARMED)) begin
         to_cnt_reg <= '0;
      end else if (to_cnt_reg != 32'(TIMEOUT)) begin
         to_cnt_reg <= to_cnt_reg + 32'd1;
      end
   end

   assign timeout_hit = (state_reg == ARMED) && (to_cnt_reg == 32'(TIMEOUT));
`else
   // No counter is built, so ARMED waits indefinitely. The term is constant
   // false for any legal (positive) TIMEOUT.
   assign timeout_hit = (TIMEOUT < 0);
`endif

   // -------------------------------------------------------------------------
   // Trigger and sample qualification
   // -------------------------------------------------------------------------
   assign in_capture = (state_reg == PRE) || (state_reg == ARMED) || (state_reg == POST);

   // start owns the cycle. The sample arriving with it is dropped, because
   // the new capture begins at address 0 on the following sample.
   assign sample_en = adc_valid && in_capture && !start;

   assign rise_hit = prev_valid_reg && (prev_reg < trig_level) && (adc_data >= trig_level);
   assign fall_hit = prev_valid_reg && (prev_reg > trig_level) && (adc_data <= trig_level);
   assign edge_hit = trig_edge ? fall_hit : rise_hit;

   assign fire = (state_reg == ARMED) && sample_en && (edge_hit || force_reg || timeout_hit);

   // -------------------------------------------------------------------------
   // Readout issue
   // -------------------------------------------------------------------------
   // A new rd_next is accepted only when no address is on the buffer this
   // cycle. It is also refused once the whole window has been issued.
   assign rd_go_start = (state_reg == DONE) && rd_start && !start;
   assign rd_go_next  = (state_reg == DONE) && rd_active_reg && rd_next && !rd_start &&
                        !start && !rd_s1_reg && (rd_cnt_reg < RD_TOTAL);

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      if (start) begin
         state_next = PRE;
      end else begin
         case (state_reg)
            PRE: begin
               if (adc_valid && (pre_cnt_reg == PRE_LAST)) begin
                  state_next = ARMED;
               end
            end
            ARMED: begin
               if (fire) begin
                  state_next = (POST_LEN == 0) ? DONE : POST;
               end
            end
            POST: begin
               if (adc_valid && (post_cnt_reg == POST_LAST)) begin
                  state_next = DONE;
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Datapath
   // -------------------------------------------------------------------------
   always_ff @(posedge clka) begin
      if (rsta) begin
         wptr_reg       <= '0;
         waddr_reg      <= '0;
         dia_reg        <= '0;
         wea_reg        <= 1'b0;
         pre_cnt_reg    <= '0;
         post_cnt_reg   <= '0;
         prev_reg       <= '0;
         prev_valid_reg <= 1'b0;
         force_reg      <= 1'b0;
         trig_addr_reg  <= '0;
         rptr_reg       <= '0;
         rd_cnt_reg     <= '0;
         rd_active_reg  <= 1'b0;
         rd_s1_reg      <= 1'b0;
         rd_last_s1_reg <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_last_reg    <= 1'b0;
      end else if (start) begin
         // Restart: clear pointers and counters, and squash any read in
         // flight. trig_addr keeps its last value until a new trigger occurs.
         wptr_reg       <= '0;
         wea_reg        <= 1'b0;
         pre_cnt_reg    <= '0;
         post_cnt_reg   <= '0;
         prev_valid_reg <= 1'b0;
         force_reg      <= 1'b0;
         rptr_reg       <= '0;
         rd_cnt_reg     <= '0;
         rd_active_reg  <= 1'b0;
         rd_s1_reg      <= 1'b0;
         rd_last_s1_reg <= 1'b0;
         rd_valid_reg   <= 1'b0;
         rd_last_reg    <= 1'b0;
      end else begin
         // Sample write, presented to the buffer one cycle after adc_valid.
         wea_reg <= sample_en;
         if (sample_en) begin
            waddr_reg      <= wptr_reg;
            dia_reg        <= adc_data;
            wptr_reg       <= wptr_reg + 1'b1;
            prev_reg       <= adc_data;
            prev_valid_reg <= 1'b1;
         end

         if ((state_reg == PRE) && adc_valid) begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
         end
         if ((state_reg == POST) && adc_valid) begin
            post_cnt_reg <= post_cnt_reg + 1'b1;
         end

         // A forced trigger is honoured only in ARMED. Pulses seen elsewhere
         // are dropped rather than carried into the next ARMED phase.
         if (state_reg == ARMED) begin
            if (fire) begin
               force_reg <= 1'b0;
            end else if (force_trig) begin
               force_reg <= 1'b1;
            end
         end else begin
            force_reg <= 1'b0;
         end

         if (fire) begin
            trig_addr_reg <= wptr_reg;
         end

         // Readout pipeline.
         //   Issue cycle: rptr is loaded or advanced.
         //   Next cycle:  addra = rptr and the buffer registers the read.
         //   Cycle after: doa is valid and rd_valid is asserted.
         if (rd_go_start) begin
            rptr_reg      <= trig_addr_reg - PRE_OFFS;
            rd_cnt_reg    <= CNT_W'(1);
            rd_active_reg <= 1'b1;
         end else if (rd_go_next) begin
            rptr_reg   <= rptr_reg + 1'b1;
            rd_cnt_reg <= rd_cnt_reg + 1'b1;
         end
         rd_s1_reg      <= rd_go_start || rd_go_next;
         rd_last_s1_reg <= rd_go_next && (rd_cnt_reg == RD_FINAL);
         rd_valid_reg   <= rd_s1_reg;
         rd_last_reg    <= rd_s1_reg && rd_last_s1_reg;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The final POST write lands in the first DONE cycle, so the write address
   // keeps priority while wea is high. After that, DONE drives the read
   // pointer.
   assign addra = wea_reg ? waddr_reg :
                  (state_reg == DONE) ? rptr_reg : waddr_reg;

   assign dia       = dia_reg;
   assign wea       = wea_reg;
   assign rd_data   = doa;
   assign rd_valid  = rd_valid_reg;
   assign rd_last   = rd_last_reg;
   assign busy      = in_capture;
   assign done      = (state_reg == DONE);
   assign trig_addr = trig_addr_reg;

endmodule

// File: tb/tb_capture_ctrl.sv
// ============================================================================
// tb_capture_ctrl -- directed, self-checking bench for capture_ctrl
//
// Provides a 4096 x 8 buffer with registered read on the DUT's buffer port.
// Drives the capture and readout scenarios and compares results against
// hand-computed values.
// Build option: CAPTURE_TIMEOUT_EN selects the timeout expectations.
// ============================================================================
module tb_capture_ctrl;

   localparam int AW    = 12;
   localparam int DW    = 8;
   localparam int DEPTH = 4096;

   logic          clka = 1'b0;
   logic          rsta;
   logic          start;
   logic [DW-1:0] adc_data;
   logic          adc_valid;
   logic [DW-1:0] trig_level;
   logic          trig_edge;
   logic          force_trig;
   logic          rd_start;
   logic          rd_next;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic          busy;
   logic          done;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] addra;
   logic [DW-1:0] dia;
   logic          wea;
   logic [DW-1:0] doa;

   logic [DW-1:0] mem [0:DEPTH-1];

   int checks = 0;
   int errors = 0;
   int sidx;      // sample index since the last start
   bit ramp;      // 1: ramp data, 0: constant 50
   int wexp;      // expected next write address
   int nwr;       // writes observed since the last start
   int wr_bad;    // write address/data mismatches
   int rd_bad;    // readout mismatches
   int n;

   always #5 clka = ~clka;

   capture_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .PRETRIG   (2048),
      .TIMEOUT   (100)
   ) dut (
      .clka      (clka),
      .rsta      (rsta),
      .start     (start),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .trig_level(trig_level),
      .trig_edge (trig_edge),
      .force_trig(force_trig),
      .rd_start  (rd_start),
      .rd_next   (rd_next),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .busy      (busy),
      .done      (done),
      .trig_addr (trig_addr),
      .addra     (addra),
      .dia       (dia),
      .wea       (wea),
      .doa       (doa)
   );

   // Buffer model: write-first is irrelevant here; read is registered.
   always @(posedge clka) begin
      if (wea) mem[addra] <= dia;
      doa <= mem[addra];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s = %0d", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   // Feed n consecutive valid samples and verify each resulting write.
   task automatic feed(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         adc_valid = 1'b1;
         adc_data  = ramp ? DW'(sidx % 256) : 8'd50;
         tick();
         if (wea) begin
            nwr++;
            if (addra !== AW'(wexp) || dia !== adc_data) wr_bad++;
            wexp++;
         end
         sidx++;
      end
      adc_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start  = 1'b0;
      wexp   = 0;
      nwr    = 0;
      wr_bad = 0;
      sidx   = 0;
   endtask

   task automatic run_to_done(input int limit, output int cnt);
      cnt = 0;
      while (!done && cnt < limit) begin
         feed(1);
         cnt++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rsta = 1'b1; start = 1'b0; adc_data = '0; adc_valid = 1'b0;
      trig_level = 8'd100; trig_edge = 1'b0; force_trig = 1'b0;
      rd_start = 1'b0; rd_next = 1'b0;
      sidx = 0; ramp = 1'b1; wexp = 0; nwr = 0; wr_bad = 0; rd_bad = 0;
      repeat (3) tick();

      // Reset values
      check("rst_wea", wea, 0);
      check("rst_addra", addra, 0);
      check("rst_dia", dia, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_trig_addr", trig_addr, 0);
      rsta = 1'b0;
      tick();

      // Ramp, rising edge at 100: trigger at sample 2148
      ramp = 1'b1; trig_edge = 1'b0;
      do_start();
      check("start_busy", busy, 1);
      run_to_done(5000, n);
      check("ramp_done", done, 1);
      check("ramp_samples", n, 4196);
      check("ramp_trig_addr", trig_addr, 2148);
      check("ramp_writes", nwr, 4196);
      check("ramp_wr_seq", wr_bad, 0);
      check("ramp_busy_low", busy, 0);
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      check("done_wea", wea, 0);

      // Readout latency: rd_start at N -> rd_valid at N+2 only
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      check("rd_n1_valid", rd_valid, 0);
      tick();
      check("rd_n2_valid", rd_valid, 1);
      check("rd_first_data", rd_data, 100);
      tick();
      check("rd_n3_valid", rd_valid, 0);

      // Remaining 4095 reads; at k==1 rd_next is held a second cycle.
      for (int k = 1; k < DEPTH; k++) begin
         rd_next = 1'b1;
         tick();
         rd_next = (k == 1);
         tick();
         rd_next = 1'b0;
         if (!rd_valid || rd_data !== DW'((100 + k) % 256) || rd_last !== (k == DEPTH - 1))
            rd_bad++;
         if (k == 2048) check("rd_sample_2049", rd_data, 100);
         if (k == DEPTH - 1) check("rd_last_final", rd_last, 1);
         if (k == 1) begin
            tick();
            check("rd_pending_ignored", rd_valid, 0);
         end
      end
      check("rd_seq", rd_bad, 0);
      rd_next = 1'b1;
      tick();
      rd_next = 1'b0;
      tick();
      check("rd_after_last", rd_valid, 0);

      // Falling edge: 255 -> 0 at the first ARMED sample
      trig_edge = 1'b1;
      do_start();
      run_to_done(5000, n);
      check("fall_trig_addr", trig_addr, 2048);
      check("fall_samples", n, 4096);
      trig_edge = 1'b0;

      // Constant 50, force in PRE ignored, force in ARMED triggers
      ramp = 1'b0;
      do_start();
      feed(2000);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      feed(58);
      check("force_armed_busy", busy, 1);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      run_to_done(3000, n);
      check("force_post_samples", n, 2048);
      check("force_trig_addr", trig_addr, 2058);
      check("force_wr_seq", wr_bad, 0);

      // start mid-POST restarts at address 0
      do_start();
      feed(2048);
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      feed(20);
      check("midpost_busy", busy, 1);
      do_start();
      check("restart_busy", busy, 1);
      check("restart_wea", wea, 0);
      feed(1);
      check("restart_addr0", addra, 0);
      feed(1);
      check("restart_addr1", addra, 1);

      // rsta together with start while ARMED
      feed(2046);
      rsta = 1'b1; start = 1'b1; adc_valid = 1'b1; adc_data = 8'd50;
      tick();
      check("rst2_wea", wea, 0);
      check("rst2_addra", addra, 0);
      check("rst2_dia", dia, 0);
      check("rst2_busy", busy, 0);
      check("rst2_done", done, 0);
      check("rst2_trig_addr", trig_addr, 0);
      check("rst2_rd_valid", rd_valid, 0);
      check("rst2_rd_last", rd_last, 0);
      rsta = 1'b0; start = 1'b0; adc_valid = 1'b0;
      feed(1);
      check("idle_wea", wea, 0);

      // Timeout behaviour with constant input
      do_start();
      feed(2048);
`ifdef CAPTURE_TIMEOUT_EN
      run_to_done(3000, n);
      check("to_done", done, 1);
      check("to_trig_addr", trig_addr, 2148);
      check("to_samples", n, 2148);
`else
      feed(300);
      check("noto_busy", busy, 1);
      check("noto_done", done, 0);
      check("noto_trig_addr", trig_addr, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
